// File: rtl/logic_analyzer_pkg.sv
// Shared constants, encodings and capture FSM state type for the logic analyzer.
// Register map, RAM window and trigger condition codes live here.
package logic_analyzer_pkg;

    localparam logic [31:0] REG_CTRL     = 32'h0000_0000;
    localparam logic [31:0] REG_MODE     = 32'h0000_0001;
    localparam logic [31:0] REG_CFG_BASE = 32'h0000_0002;

    localparam int RAM_SEL_BIT = 24;
    localparam int RAM_AW      = 10;
    localparam int RAM_DEPTH   = 1024;
    localparam logic [RAM_AW-1:0] RAM_LAST_IDX = 10'd1023;

    localparam logic [2:0] OP_PASS  = 3'b000;
    localparam logic [2:0] OP_INV   = 3'b001;

    localparam logic [2:0] VAL_LOW  = 3'b000;
    localparam logic [2:0] VAL_HIGH = 3'b001;
    localparam logic [2:0] VAL_RISE = 3'b010;
    localparam logic [2:0] VAL_FALL = 3'b011;
    localparam logic [2:0] VAL_EDGE = 3'b100;

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_IMM = 2'b10;

    localparam logic [5:0] CFG_RESET  = 6'b000111;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } la_state_e;

    function automatic logic cfg_is_dont_care(input logic [2:0] val);
        return (val > VAL_EDGE);
    endfunction

endpackage

// File: rtl/logic_analyzer_trigger.sv
// Per-channel trigger condition evaluation and reduction according to MODE.
// Don't-care channels are excluded from the reduction; all don't-care fires at once.
module logic_analyzer_trigger
    import logic_analyzer_pkg::*;
#(
    parameter int DIGITAL_IN_NUM = 8
)
(
    input  logic [DIGITAL_IN_NUM-1:0]      i_level,
    input  logic [DIGITAL_IN_NUM-1:0]      i_rise,
    input  logic [DIGITAL_IN_NUM-1:0]      i_fall,
    input  logic [DIGITAL_IN_NUM-1:0][5:0] i_cfg,
    input  logic [1:0]                     i_mode,
    output logic                           o_trigger
);

    logic [DIGITAL_IN_NUM-1:0] w_raw;
    logic [DIGITAL_IN_NUM-1:0] w_care;
    logic [DIGITAL_IN_NUM-1:0] w_cond;
    logic w_any;
    logic w_and;
    logic w_or;

    // Raw condition, care flag and optional inversion per channel
    always_comb begin
        w_raw  = '0;
        w_care = '0;
        w_cond = '0;
        for (int k = 0; k < DIGITAL_IN_NUM; k++) begin
            case (i_cfg[k][2:0])
                VAL_LOW:  w_raw[k] = ~i_level[k];
                VAL_HIGH: w_raw[k] = i_level[k];
                VAL_RISE: w_raw[k] = i_rise[k];
                VAL_FALL: w_raw[k] = i_fall[k];
                VAL_EDGE: w_raw[k] = i_rise[k] | i_fall[k];
                default:  w_raw[k] = 1'b0;
            endcase
            w_care[k] = !cfg_is_dont_care(i_cfg[k][2:0]);
            w_cond[k] = (i_cfg[k][5:3] == OP_INV) ? ~w_raw[k] : w_raw[k];
        end
    end

    assign w_any = |w_care;
    assign w_and = &(w_cond | ~w_care);
    assign w_or  = |(w_cond & w_care);

    // Mode reduction; reserved mode 11 behaves like AND
    always_comb begin
        o_trigger = 1'b0;
        case (i_mode)
            MODE_IMM: o_trigger = 1'b1;
            MODE_OR:  o_trigger = !w_any || w_or;
            default:  o_trigger = !w_any || w_and;
        endcase
    end

endmodule

// File: rtl/logic_analyzer.sv
// Logic analyzer: synchronized probes, programmable trigger, 1024-sample capture RAM,
// and a single-outstanding AXI slave for register and RAM access.
module logic_analyzer
    import logic_analyzer_pkg::*;
#(
    parameter int DIGITAL_IN_NUM = 8
)
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DIGITAL_IN_NUM-1:0] digital_in,
    output logic                      ANALYZER_SLAVE_CLK,
    output logic                      ANALYZER_SLAVE_RSTN,
    input  logic [3:0]                ANALYZER_SLAVE_WR_ADDR_ID,
    input  logic [31:0]               ANALYZER_SLAVE_WR_ADDR,
    input  logic [7:0]                ANALYZER_SLAVE_WR_ADDR_LEN,
    input  logic [1:0]                ANALYZER_SLAVE_WR_ADDR_BURST,
    input  logic                      ANALYZER_SLAVE_WR_ADDR_VALID,
    output logic                      ANALYZER_SLAVE_WR_ADDR_READY,
    input  logic [31:0]               ANALYZER_SLAVE_WR_DATA,
    input  logic [3:0]                ANALYZER_SLAVE_WR_STRB,
    input  logic                      ANALYZER_SLAVE_WR_DATA_LAST,
    input  logic                      ANALYZER_SLAVE_WR_DATA_VALID,
    output logic                      ANALYZER_SLAVE_WR_DATA_READY,
    output logic [3:0]                ANALYZER_SLAVE_WR_BACK_ID,
    output logic [1:0]                ANALYZER_SLAVE_WR_BACK_RESP,
    output logic                      ANALYZER_SLAVE_WR_BACK_VALID,
    input  logic                      ANALYZER_SLAVE_WR_BACK_READY,
    input  logic [3:0]                ANALYZER_SLAVE_RD_ADDR_ID,
    input  logic [31:0]               ANALYZER_SLAVE_RD_ADDR,
    input  logic [7:0]                ANALYZER_SLAVE_RD_ADDR_LEN,
    input  logic [1:0]                ANALYZER_SLAVE_RD_ADDR_BURST,
    input  logic                      ANALYZER_SLAVE_RD_ADDR_VALID,
    output logic                      ANALYZER_SLAVE_RD_ADDR_READY,
    output logic [3:0]                ANALYZER_SLAVE_RD_BACK_ID,
    output logic [31:0]               ANALYZER_SLAVE_RD_DATA,
    output logic [1:0]                ANALYZER_SLAVE_RD_DATA_RESP,
    output logic                      ANALYZER_SLAVE_RD_DATA_LAST,
    output logic                      ANALYZER_SLAVE_RD_DATA_VALID,
    input  logic                      ANALYZER_SLAVE_RD_DATA_READY
);

    localparam int N = DIGITAL_IN_NUM;

    logic [N-1:0]      r_sync1, r_sync2, r_prev;
    logic [N-1:0]      w_rise, w_fall;
    logic [1:0]        r_mode;
    logic [N-1:0][5:0] r_cfg;
    la_state_e         r_state, w_state_next;
    logic [RAM_AW-1:0] r_cap_addr;
    logic              w_trigger, w_ram_we, w_arm, w_stop;
    logic [N-1:0]      r_ram [0:RAM_DEPTH-1];
    logic [31:0]       w_status;

    logic        r_wr_addr_ready, r_wr_data_ready, r_wr_back_valid;
    logic [3:0]  r_wr_id;
    logic [31:0] r_wr_addr;
    logic [1:0]  r_wr_burst;
    logic        w_wr_beat;

    logic        r_rd_addr_ready, r_rd_valid, r_rd_last;
    logic [3:0]  r_rd_id;
    logic [31:0] r_rd_addr, r_rd_data;
    logic [1:0]  r_rd_burst;
    logic [7:0]  r_rd_cnt;
    logic [31:0] w_rd_next_addr, w_rd_fetch_addr, w_rd_word;
    logic        w_unused;

    assign w_unused = ^{ANALYZER_SLAVE_WR_ADDR_LEN, ANALYZER_SLAVE_WR_STRB, ANALYZER_SLAVE_WR_DATA[31:6]};

    // Two-flop synchronizer plus previous sample for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= digital_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;

    logic_analyzer_trigger #(.DIGITAL_IN_NUM(N)) u_trigger (
        .i_level   (r_sync2),
        .i_rise    (w_rise),
        .i_fall    (w_fall),
        .i_cfg     (r_cfg),
        .i_mode    (r_mode),
        .o_trigger (w_trigger)
    );

    assign w_wr_beat = r_wr_data_ready && ANALYZER_SLAVE_WR_DATA_VALID;
    assign w_arm     = w_wr_beat && (r_wr_addr == REG_CTRL) && ANALYZER_SLAVE_WR_DATA[0];
    assign w_stop    = w_wr_beat && (r_wr_addr == REG_CTRL) && !ANALYZER_SLAVE_WR_DATA[0];

    // Capture FSM next state; the triggering sample is written at index 0
    always_comb begin
        w_state_next = r_state;
        w_ram_we     = 1'b0;
        if (w_arm) begin
            w_state_next = ST_ARMED;
        end else if (w_stop) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_trigger) begin
                        w_ram_we     = 1'b1;
                        w_state_next = ST_CAPTURE;
                    end else begin
                        w_state_next = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    w_ram_we = 1'b1;
                    if (r_cap_addr == RAM_LAST_IDX) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_CAPTURE;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Capture FSM state and write pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_cap_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_arm) begin
                r_cap_addr <= '0;
            end else if (w_ram_we) begin
                r_cap_addr <= r_cap_addr + 10'd1;
            end
        end
    end

    // Sample RAM write port (contents not reset)
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_cap_addr] <= r_sync2;
        end
    end

    // MODE and channel CFG registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode <= MODE_AND;
            r_cfg  <= {N{CFG_RESET}};
        end else if (w_wr_beat) begin
            if (r_wr_addr == REG_MODE) begin
                r_mode <= ANALYZER_SLAVE_WR_DATA[1:0];
            end
            for (int k = 0; k < N; k++) begin
                if (r_wr_addr == REG_CFG_BASE + 32'(k)) begin
                    r_cfg[k] <= ANALYZER_SLAVE_WR_DATA[5:0];
                end
            end
        end
    end

    // Write channel: address, data beats, then response until accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_addr_ready <= 1'b0;
            r_wr_data_ready <= 1'b0;
            r_wr_back_valid <= 1'b0;
            r_wr_id         <= 4'd0;
            r_wr_addr       <= 32'd0;
            r_wr_burst      <= 2'd0;
        end else if (r_wr_addr_ready && ANALYZER_SLAVE_WR_ADDR_VALID) begin
            r_wr_addr_ready <= 1'b0;
            r_wr_data_ready <= 1'b1;
            r_wr_id         <= ANALYZER_SLAVE_WR_ADDR_ID;
            r_wr_addr       <= ANALYZER_SLAVE_WR_ADDR;
            r_wr_burst      <= ANALYZER_SLAVE_WR_ADDR_BURST;
        end else if (w_wr_beat) begin
            if (r_wr_burst == BURST_INCR) begin
                r_wr_addr <= r_wr_addr + 32'd1;
            end
            if (ANALYZER_SLAVE_WR_DATA_LAST) begin
                r_wr_data_ready <= 1'b0;
                r_wr_back_valid <= 1'b1;
            end
        end else if (r_wr_back_valid && ANALYZER_SLAVE_WR_BACK_READY) begin
            r_wr_back_valid <= 1'b0;
            r_wr_addr_ready <= 1'b1;
        end else if (!r_wr_data_ready && !r_wr_back_valid) begin
            r_wr_addr_ready <= 1'b1;
        end
    end

    assign w_status = {29'd0, r_state == ST_DONE,
                       (r_state == ST_CAPTURE) || (r_state == ST_DONE), r_state == ST_ARMED};

    assign w_rd_next_addr  = (r_rd_burst == BURST_INCR) ? r_rd_addr + 32'd1 : r_rd_addr;
    assign w_rd_fetch_addr = r_rd_valid ? w_rd_next_addr : ANALYZER_SLAVE_RD_ADDR;

    // Read decode for the word about to be presented
    always_comb begin
        w_rd_word = 32'd0;
        if (w_rd_fetch_addr[RAM_SEL_BIT]) begin
            w_rd_word = 32'(r_ram[w_rd_fetch_addr[RAM_AW-1:0]]);
        end else if (w_rd_fetch_addr == REG_CTRL) begin
            w_rd_word = w_status;
        end else if (w_rd_fetch_addr == REG_MODE) begin
            w_rd_word = {30'd0, r_mode};
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_rd_fetch_addr == REG_CFG_BASE + 32'(k)) begin
                    w_rd_word = {26'd0, r_cfg[k]};
                end
            end
        end
    end

    // Read channel: data register only advances on an accepted beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_addr_ready <= 1'b0;
            r_rd_valid      <= 1'b0;
            r_rd_last       <= 1'b0;
            r_rd_id         <= 4'd0;
            r_rd_addr       <= 32'd0;
            r_rd_burst      <= 2'd0;
            r_rd_cnt        <= 8'd0;
            r_rd_data       <= 32'd0;
        end else if (r_rd_addr_ready && ANALYZER_SLAVE_RD_ADDR_VALID) begin
            r_rd_addr_ready <= 1'b0;
            r_rd_valid      <= 1'b1;
            r_rd_id         <= ANALYZER_SLAVE_RD_ADDR_ID;
            r_rd_addr       <= ANALYZER_SLAVE_RD_ADDR;
            r_rd_burst      <= ANALYZER_SLAVE_RD_ADDR_BURST;
            r_rd_cnt        <= ANALYZER_SLAVE_RD_ADDR_LEN;
            r_rd_last       <= (ANALYZER_SLAVE_RD_ADDR_LEN == 8'd0);
            r_rd_data       <= w_rd_word;
        end else if (r_rd_valid && ANALYZER_SLAVE_RD_DATA_READY) begin
            if (r_rd_last) begin
                r_rd_valid      <= 1'b0;
                r_rd_last       <= 1'b0;
                r_rd_addr_ready <= 1'b1;
            end else begin
                r_rd_addr <= w_rd_next_addr;
                r_rd_cnt  <= r_rd_cnt - 8'd1;
                r_rd_last <= (r_rd_cnt == 8'd1);
                r_rd_data <= w_rd_word;
            end
        end else if (!r_rd_valid) begin
            r_rd_addr_ready <= 1'b1;
        end
    end

    assign ANALYZER_SLAVE_CLK           = clk;
    assign ANALYZER_SLAVE_RSTN          = rstn;
    assign ANALYZER_SLAVE_WR_ADDR_READY = r_wr_addr_ready;
    assign ANALYZER_SLAVE_WR_DATA_READY = r_wr_data_ready;
    assign ANALYZER_SLAVE_WR_BACK_ID    = r_wr_id;
    assign ANALYZER_SLAVE_WR_BACK_RESP  = RESP_OKAY;
    assign ANALYZER_SLAVE_WR_BACK_VALID = r_wr_back_valid;
    assign ANALYZER_SLAVE_RD_ADDR_READY = r_rd_addr_ready;
    assign ANALYZER_SLAVE_RD_BACK_ID    = r_rd_id;
    assign ANALYZER_SLAVE_RD_DATA       = r_rd_data;
    assign ANALYZER_SLAVE_RD_DATA_RESP  = RESP_OKAY;
    assign ANALYZER_SLAVE_RD_DATA_LAST  = r_rd_last;
    assign ANALYZER_SLAVE_RD_DATA_VALID = r_rd_valid;

endmodule

// File: tb/tb_logic_analyzer.sv
// Directed self-checking bench for logic_analyzer: registers, trigger, capture and AXI bursts.
module tb_logic_analyzer;

    logic clk = 1'b0;
    logic rstn;
    logic [7:0] manual_in;
    logic [7:0] cnt = 8'd0;
    logic cnt_en;
    wire  [7:0] digital_in = cnt_en ? cnt : manual_in;

    logic slave_clk, slave_rstn;
    logic [3:0] aw_id;  logic [31:0] aw_addr; logic [7:0] aw_len; logic [1:0] aw_burst;
    logic aw_valid, aw_ready;
    logic [31:0] w_data; logic [3:0] w_strb; logic w_last, w_valid, w_ready;
    logic [3:0] b_id; logic [1:0] b_resp; logic b_valid, b_ready;
    logic [3:0] ar_id;  logic [31:0] ar_addr; logic [7:0] ar_len; logic [1:0] ar_burst;
    logic ar_valid, ar_ready;
    logic [3:0] r_id; logic [31:0] r_data; logic [1:0] r_resp; logic r_last, r_valid, r_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_buf [0:255];
    logic [31:0] b0;
    logic [7:0]  exp8;

    always #5 clk = ~clk;
    always @(negedge clk) cnt <= cnt + 8'd1;

    logic_analyzer #(.DIGITAL_IN_NUM(8)) dut (
        .clk(clk), .rstn(rstn), .digital_in(digital_in),
        .ANALYZER_SLAVE_CLK(slave_clk), .ANALYZER_SLAVE_RSTN(slave_rstn),
        .ANALYZER_SLAVE_WR_ADDR_ID(aw_id), .ANALYZER_SLAVE_WR_ADDR(aw_addr),
        .ANALYZER_SLAVE_WR_ADDR_LEN(aw_len), .ANALYZER_SLAVE_WR_ADDR_BURST(aw_burst),
        .ANALYZER_SLAVE_WR_ADDR_VALID(aw_valid), .ANALYZER_SLAVE_WR_ADDR_READY(aw_ready),
        .ANALYZER_SLAVE_WR_DATA(w_data), .ANALYZER_SLAVE_WR_STRB(w_strb),
        .ANALYZER_SLAVE_WR_DATA_LAST(w_last), .ANALYZER_SLAVE_WR_DATA_VALID(w_valid),
        .ANALYZER_SLAVE_WR_DATA_READY(w_ready), .ANALYZER_SLAVE_WR_BACK_ID(b_id),
        .ANALYZER_SLAVE_WR_BACK_RESP(b_resp), .ANALYZER_SLAVE_WR_BACK_VALID(b_valid),
        .ANALYZER_SLAVE_WR_BACK_READY(b_ready),
        .ANALYZER_SLAVE_RD_ADDR_ID(ar_id), .ANALYZER_SLAVE_RD_ADDR(ar_addr),
        .ANALYZER_SLAVE_RD_ADDR_LEN(ar_len), .ANALYZER_SLAVE_RD_ADDR_BURST(ar_burst),
        .ANALYZER_SLAVE_RD_ADDR_VALID(ar_valid), .ANALYZER_SLAVE_RD_ADDR_READY(ar_ready),
        .ANALYZER_SLAVE_RD_BACK_ID(r_id), .ANALYZER_SLAVE_RD_DATA(r_data),
        .ANALYZER_SLAVE_RD_DATA_RESP(r_resp), .ANALYZER_SLAVE_RD_DATA_LAST(r_last),
        .ANALYZER_SLAVE_RD_DATA_VALID(r_valid), .ANALYZER_SLAVE_RD_DATA_READY(r_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] id, input logic [3:0] strb);
        int n;
        @(negedge clk);
        aw_id = id; aw_addr = addr; aw_len = 8'd0; aw_burst = 2'b01; aw_valid = 1'b1;
        n = 0;
        while (!aw_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("wr_addr_handshake", 32'(n < 100), 32'd1);
        @(negedge clk);
        aw_valid = 1'b0;
        check_eq("wr_data_ready", 32'(w_ready), 32'd1);
        w_data = data; w_strb = strb; w_last = 1'b1; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        check_eq("wr_back_valid", 32'(b_valid), 32'd1);
        check_eq("wr_back_id", 32'(b_id), 32'(id));
        check_eq("wr_back_resp", 32'(b_resp), 32'd0);
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input bit toggle);
        int n, beat, cyc;
        logic held;
        logic [31:0] held_data;
        @(negedge clk);
        ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
        n = 0;
        while (!ar_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_addr_handshake", 32'(n < 100), 32'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        check_eq("rd_first_valid", 32'(r_valid), 32'd1);
        beat = 0; cyc = 0; held = 1'b0; held_data = 32'd0;
        while (beat <= int'(len) && cyc < 4000) begin
            r_ready = toggle ? cyc[0] : 1'b1;
            if (held && r_valid) check_eq("rd_data_hold", r_data, held_data);
            held = 1'b0;
            if (r_valid && r_ready) begin
                rd_buf[beat] = r_data;
                check_eq("rd_id", 32'(r_id), 32'(id));
                check_eq("rd_resp", 32'(r_resp), 32'd0);
                check_eq("rd_last", 32'(r_last), 32'(beat == int'(len)));
                beat++;
            end else if (r_valid) begin
                held = 1'b1;
                held_data = r_data;
            end
            @(negedge clk);
            cyc++;
        end
        r_ready = 1'b0;
        check_eq("rd_beat_count", 32'(beat), 32'(len) + 32'd1);
        check_eq("rd_valid_after_last", 32'(r_valid), 32'd0);
    endtask

    task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        axi_read(addr, 8'd0, 2'b01, 4'd1, 1'b0);
        check_eq(tag, rd_buf[0], exp);
    endtask

    initial begin
        rstn = 1'b0; cnt_en = 1'b0; manual_in = 8'h00;
        aw_id = 4'd0; aw_addr = 32'd0; aw_len = 8'd0; aw_burst = 2'd0; aw_valid = 1'b0;
        w_data = 32'd0; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
        ar_id = 4'd0; ar_addr = 32'd0; ar_len = 8'd0; ar_burst = 2'd0; ar_valid = 1'b0;
        r_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_wr_addr_ready", 32'(aw_ready), 32'd0);
        check_eq("reset_rd_addr_ready", 32'(ar_ready), 32'd0);
        check_eq("reset_back_valid", 32'(b_valid), 32'd0);
        check_eq("reset_rd_valid", 32'(r_valid), 32'd0);
        check_eq("reset_slave_rstn", 32'(slave_rstn), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_wr_addr_ready", 32'(aw_ready), 32'd1);
        check_eq("idle_rd_addr_ready", 32'(ar_ready), 32'd1);

        read_word("status_reset", 32'h0, 32'h0);
        read_word("cfg0_reset", 32'h2, 32'h07);
        read_word("mode_reset", 32'h1, 32'h0);
        read_word("unmapped_read", 32'h100, 32'h0);
        read_word("cfg_beyond_ch7", 32'hA, 32'h0);

        axi_write(32'h1, 32'h0, 4'd2, 4'hF);
        axi_write(32'h2, 32'h00, 4'd3, 4'hF);
        axi_write(32'h3, 32'h09, 4'd4, 4'hF);
        read_word("cfg1_readback", 32'h3, 32'h09);
        manual_in = 8'h03;
        repeat (4) @(negedge clk);
        axi_write(32'h0, 32'h1, 4'd5, 4'hF);
        repeat (8) @(negedge clk);
        read_word("armed_no_trig_03", 32'h0, 32'h1);
        manual_in = 8'h00;
        repeat (8) @(negedge clk);
        read_word("triggered_at_00", 32'h0, 32'h2);
        read_word("ram0_trigger_sample", 32'h0100_0000, 32'h0);
        repeat (1100) @(negedge clk);
        read_word("done_after_trigger", 32'h0, 32'h6);

        manual_in = 8'h03;
        repeat (4) @(negedge clk);
        axi_write(32'h0, 32'h1, 4'd6, 4'hF);
        read_word("rearmed", 32'h0, 32'h1);
        axi_write(32'h0, 32'h0, 4'd7, 4'hF);
        read_word("stopped", 32'h0, 32'h0);
        axi_write(32'h0, 32'h1, 4'd8, 4'hF);
        read_word("restart_armed", 32'h0, 32'h1);
        manual_in = 8'h00;
        repeat (1100) @(negedge clk);
        read_word("restart_done", 32'h0, 32'h6);

        cnt_en = 1'b1;
        axi_write(32'h1, 32'h2, 4'd9, 4'hF);
        axi_write(32'h0, 32'h1, 4'd10, 4'hF);
        repeat (1005) @(negedge clk);
        read_word("imm_still_capturing", 32'h0, 32'h2);
        repeat (30) @(negedge clk);
        read_word("imm_done", 32'h0, 32'h6);

        axi_read(32'h0100_0000, 8'd255, 2'b01, 4'd5, 1'b0);
        b0 = rd_buf[0];
        check_eq("ram_zero_extend", b0 & 32'hFFFF_FF00, 32'h0);
        for (int i = 1; i < 256; i++) begin
            exp8 = b0[7:0] + 8'(i);
            check_eq("incr_sample", rd_buf[i], {24'd0, exp8});
        end

        for (int j = 0; j < 4; j++) begin
            axi_read(32'h0100_0000 + 32'(j * 256), 8'd255, 2'b01, 4'(j + 1), 1'b0);
            for (int i = 0; i < 256; i++) begin
                exp8 = b0[7:0] + 8'(j * 256 + i);
                check_eq("contig_sample", rd_buf[i], {24'd0, exp8});
            end
        end

        axi_read(32'h0100_03FE, 8'd3, 2'b01, 4'd11, 1'b0);
        exp8 = b0[7:0] + 8'd254; check_eq("wrap_1022", rd_buf[0], {24'd0, exp8});
        exp8 = b0[7:0] + 8'd255; check_eq("wrap_1023", rd_buf[1], {24'd0, exp8});
        check_eq("wrap_0", rd_buf[2], b0);
        exp8 = b0[7:0] + 8'd1;   check_eq("wrap_1", rd_buf[3], {24'd0, exp8});

        axi_read(32'h0100_0005, 8'd3, 2'b00, 4'd12, 1'b0);
        exp8 = b0[7:0] + 8'd5;
        for (int i = 0; i < 4; i++) check_eq("fixed_burst", rd_buf[i], {24'd0, exp8});

        axi_read(32'h0100_0000, 8'd255, 2'b01, 4'd13, 1'b1);
        for (int i = 0; i < 256; i++) begin
            exp8 = b0[7:0] + 8'(i);
            check_eq("toggle_sample", rd_buf[i], {24'd0, exp8});
        end

        axi_write(32'h0100_0000, 32'h0000_00FF, 4'd14, 4'hF);
        read_word("ram_write_dropped", 32'h0100_0000, b0);
        axi_write(32'h1, 32'h1, 4'd15, 4'h0);
        read_word("strb_ignored", 32'h1, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_analyzer.md
LOGIC_ANALYZER -- requirements
Module: logic_analyzer

Interface
REQ-001 SHALL have parameter DIGITAL_IN_NUM, default 8, number of sampled channels (1..32).
REQ-002 SHALL have clk, input, 1, sole clock for sampling and AXI logic.
REQ-003 SHALL have rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have digital_in, input, DIGITAL_IN_NUM, asynchronous probe inputs.
REQ-005 SHALL have ANALYZER_SLAVE_CLK and ANALYZER_SLAVE_RSTN, outputs, 1 each, driven directly from clk and rstn.
REQ-006 SHALL have the AXI slave write ports: WR_ADDR_ID in 4, WR_ADDR in 32, WR_ADDR_LEN in 8, WR_ADDR_BURST in 2, WR_ADDR_VALID in 1, WR_ADDR_READY out 1, WR_DATA in 32, WR_STRB in 4, WR_DATA_LAST in 1, WR_DATA_VALID in 1, WR_DATA_READY out 1, WR_BACK_ID out 4, WR_BACK_RESP out 2, WR_BACK_VALID out 1, WR_BACK_READY in 1, all prefixed ANALYZER_SLAVE_.
REQ-007 SHALL have the AXI slave read ports: RD_ADDR_ID in 4, RD_ADDR in 32, RD_ADDR_LEN in 8, RD_ADDR_BURST in 2, RD_ADDR_VALID in 1, RD_ADDR_READY out 1, RD_BACK_ID out 4, RD_DATA out 32, RD_DATA_RESP out 2, RD_DATA_LAST out 1, RD_DATA_VALID out 1, RD_DATA_READY in 1, all prefixed ANALYZER_SLAVE_.

Function
REQ-008 SHALL pass digital_in through a 2-flop synchronizer and take rise and fall edges from the synchronized value and its previous sample.
REQ-009 SHALL decode the register map: word 0x0 CTRL/STATUS (write bit0 1 = arm, 0 = stop to IDLE; read {29'b0, done, triggered, armed}); 0x1 MODE[1:0]; 0x2+k CFG of channel k ({op[5:3], val[2:0]}).
REQ-010 SHALL decode the capture RAM at address[24]=1, word index address[9:0], 1024 words, with each sample zero-extended to 32 bits.
REQ-011 SHALL define channel condition raw as: val 000 = level 0, 001 = level 1, 010 = rising, 011 = falling, 100 = either edge, 101-111 = don't-care.
REQ-012 SHALL apply op 000 as condition = raw and op 001 as condition = !raw; don't-care is never inverted.
REQ-013 SHALL define MODE as: 00 = AND of all non-don't-care conditions, 01 = OR of them, 10 = immediate trigger, 11 = treated as 00; when all channels are don't-care, the trigger fires immediately.
REQ-014 SHALL run the FSM IDLE -> ARMED (arm write) -> CAPTURE (trigger true) -> DONE (1024th sample written).
REQ-015 SHALL, from any state, go to IDLE on a stop write, and SHALL restart capture from address 0 on an arm write.
REQ-016 SHALL, in CAPTURE, write one sample per clk at an incrementing address; the sample that satisfies the trigger is stored at address 0.
REQ-017 SHALL handle one transaction per direction at a time: ADDR_READY is high only when that channel is idle, and WR_DATA_READY is high during the write data phase.
REQ-018 SHALL apply a write beat only on a WR_DATA_VALID && WR_DATA_READY handshake; writes to RAM or unmapped addresses are dropped.
REQ-019 SHALL raise WR_BACK_VALID the cycle after the beat carrying WR_DATA_LAST, with BACK_ID = WR_ADDR_ID and RESP = 00, and hold it until WR_BACK_READY.
REQ-020 SHALL support reads of LEN+1 beats with addresses incrementing by 1 for BURST 01 and constant for BURST 00; the first RD_DATA_VALID follows one cycle after the address handshake.
REQ-021 SHALL drive RD_DATA_LAST on the final beat, RD_DATA_RESP = 00 and RD_BACK_ID = RD_ADDR_ID.
REQ-022 SHALL hold RD_DATA stable while RD_DATA_READY is low.
REQ-023 SHALL return 0 for unmapped reads.
REQ-024 SHALL, on a RAM index wrap from 1023 to 0 within a burst, continue from index 0.
REQ-025 SHALL ignore WR_STRB; the whole word is written.

Reset
REQ-026 SHALL put all outputs low/zero on reset, except ANALYZER_SLAVE_CLK = clk and ANALYZER_SLAVE_RSTN = rstn.
REQ-027 SHALL, on reset, set FSM = IDLE, MODE = 00 and every CFG = 6'b000111; RAM contents are undefined.
REQ-028 SHALL let reset mid-transaction abort the transaction without issuing a response.

Structure
REQ-029 SHALL place the register offsets, RAM base/depth, op/val codes, mode codes and the FSM enum in the shared package logic_analyzer_pkg.
REQ-030 SHALL implement the per-channel condition evaluation plus the mode reduction in one sub-module, logic_analyzer_trigger.

Verification
REQ-031 SHALL check: after reset, read 0x0 -> 0x0; read 0x2 -> 0x07; WR/RD_ADDR_READY = 1.
REQ-032 SHALL check: write MODE = 00, CFG0 = 6'b000000, CFG1 = 6'b001001, arm; drive digital_in = 8'h03 and then 8'h00 -> triggered only at 8'h00; RAM[0] = 0x00000000.
REQ-033 SHALL check: MODE = 10, arm, digital_in counting 0..255 -> done after 1024 cycles; a read of 0x01000000 with LEN = 255 and INCR returns incrementing values and asserts LAST on beat 256.
REQ-034 SHALL check: four INCR LEN-255 reads at 0x01000000, 0x01000100, 0x01000200 and 0x01000300 -> 1024 contiguous samples, RESP = 00, and IDs echoed.
REQ-035 SHALL check: RD_DATA_READY toggled every other cycle during a burst -> no beat lost or duplicated.
REQ-036 SHALL check: a stop write during ARMED -> status 0; a subsequent arm write restarts cleanly.
